// File: rtl/multi_4bits.sv
// -----------------------------------------------------------------------------
// multi_4bits : free-running unsigned multiplier, P = A * B.
//
// Default build: iterative shift-add datapath driven by a four-state FSM
// (IDLE / LOAD / CALC / DONE).
//   - It watches the operand inputs and recomputes whenever they differ from
//     the operands it last latched.
//   - A new product appears bits+2 edges after the change is sampled.
//   - P is written only from DONE, and only when the operands were stable for
//     the whole computation, so a stale or partial product is never published.
//
// Build option MULTI_COMB_EN:
//   - When defined, the FSM is compiled out.
//   - The combinational product A*B is registered every cycle (1-cycle latency).
//
// Reset (rst) is asynchronous and active-high and clears all state.
// -----------------------------------------------------------------------------
module multi_4bits #(
  parameter int bits = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [bits-1:0]   A,
  input  logic [bits-1:0]   B,
  output logic [2*bits-1:0] P
);

  localparam int PW = 2 * bits;

  logic [PW-1:0] p_d;
  logic [PW-1:0] p_q;

`ifdef MULTI_COMB_EN

  // Single-cycle product: multiply the live inputs at full product width.
  always_comb begin
    p_d = PW'(A) * PW'(B);
  end

  // Register the product; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= {PW{1'b0}};
    end else begin
      p_q <= p_d;
    end
  end

`else

  // Counter wide enough to reach 'bits' so the final increment cannot wrap.
  localparam int CW = (bits < 2) ? 1 : $clog2(bits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_d;
  state_t        state_q;

  logic [bits-1:0] opa_d;
  logic [bits-1:0] opa_q;
  logic [bits-1:0] opb_d;
  logic [bits-1:0] opb_q;

  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_d;
  logic [PW-1:0]   mcand_q;
  logic [bits-1:0] mplier_d;
  logic [bits-1:0] mplier_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_q;

  logic            op_chg_s;
  logic            last_step_s;

  // Operand-change detect and the final CALC step marker.
  always_comb begin
    op_chg_s    = (A != opa_q) || (B != opb_q);
    last_step_s = (cnt_q == CW'(bits - 1));
  end

  // State register and datapath flops; reset clears everything to IDLE/zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= {bits{1'b0}};
      opb_q    <= {bits{1'b0}};
      acc_q    <= {PW{1'b0}};
      mcand_q  <= {PW{1'b0}};
      mplier_q <= {bits{1'b0}};
      cnt_q    <= {CW{1'b0}};
      p_q      <= {PW{1'b0}};
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // Next-state logic: any operand change outside IDLE aborts back to LOAD.
  // LOAD latches the live inputs, so it always proceeds to CALC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (op_chg_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = CALC;
      end
      CALC: begin
        if (op_chg_s) begin
          state_d = LOAD;
        end else if (last_step_s) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (op_chg_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath/output logic: load operands, run shift-add steps,
  // and publish the accumulator only when the operands stayed stable.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        p_d = p_q;
      end
      LOAD: begin
        opa_d    = A;
        opb_d    = B;
        acc_d    = {PW{1'b0}};
        mcand_d  = PW'(A);
        mplier_d = B;
        cnt_d    = {CW{1'b0}};
      end
      CALC: begin
        if (op_chg_s) begin
          // Abandoned computation: hold; LOAD reinitialises everything.
          acc_d = acc_q;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (op_chg_s) begin
          p_d = p_q;
        end else begin
          p_d = acc_q;
        end
      end
      default: begin
        p_d = p_q;
      end
    endcase
  end

`endif

  assign P = p_q;

endmodule

// File: tb/tb_multi_4bits.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multi_4bits (bits = 4).
// Expected products are pushed to a scoreboard queue when operands are driven
// and popped when the product is sampled. Sampling happens on negedge clk.
// -----------------------------------------------------------------------------
module tb_multi_4bits;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] p;

  int n_checks;
  int n_errors;

  logic [7:0] exp_q[$];

  multi_4bits #(.bits(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .P   (p)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive operands; optionally push the reference product.
  task automatic apply(input logic [3:0] av, input logic [3:0] bv, input bit push);
    logic [7:0] e;
    a = av;
    b = bv;
    e = {4'b0000, av} * {4'b0000, bv};
    if (push) exp_q.push_back(e);
  endtask

  // Pop the oldest expected product and compare it with P now.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, {8'h00, p}, {8'h00, e});
    end
  endtask

  // Wait up to max_cyc negedges for P to equal the oldest expected value,
  // then pop and compare (a timeout shows up as a failed compare).
  task automatic wait_pop_check(input string tag, input int max_cyc);
    logic [7:0] e;
    int k;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q[0];
      k = 0;
      while ((p !== e) && (k < max_cyc)) begin
        @(negedge clk);
        k++;
      end
      pop_check(tag);
    end
  endtask

  initial begin
    logic seen42;
    logic stable;
    n_checks = 0;
    n_errors = 0;

    // Reset with zero operands
    rst = 1'b1;
    a = 4'd0;
    b = 4'd0;
    #3;
    check_val("p_in_reset", {8'h00, p}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(10);
    check_val("p_after_reset", {8'h00, p}, 16'd0);

    // Basic products
    apply(4'd3, 4'd5, 1'b1);
    cycles(10);
    pop_check("p_3x5");
    apply(4'd15, 4'd15, 1'b1);
    cycles(10);
    pop_check("p_15x15");

    // Zero operand: old product held until DONE, exact latency of 6 edges
    apply(4'd0, 4'd9, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (p !== 8'd225) stable = 1'b0;
    end
    check_val("hold_225_during_calc", {15'd0, stable}, 16'd1);
    @(negedge clk);
    pop_check("p_0x9_latency");

    // Interrupted computation must never publish 42
    seen42 = 1'b0;
    apply(4'd7, 4'd6, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (p == 8'd42) seen42 = 1'b1;
    end
    apply(4'd9, 4'd9, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (p == 8'd42) seen42 = 1'b1;
    end
    check_val("never_42", {15'd0, seen42}, 16'd0);
    pop_check("p_9x9");
    cycles(3);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        apply(4'(ia), 4'(ib), 1'b1);
        cycles(10);
        pop_check($sformatf("sweep_%0dx%0d", ia, ib));
      end
    end

    // Async reset in the middle of CALC (prior P = 225)
    apply(4'd13, 4'd11, 1'b1);
    cycles(4);
    check_val("hold_before_rst", {8'h00, p}, 16'd225);
    #2;
    rst = 1'b1;
    #1;
    check_val("p_async_clear", {8'h00, p}, 16'd0);
    @(negedge clk);
    check_val("p_held_in_reset", {8'h00, p}, 16'd0);
    rst = 1'b0;
    wait_pop_check("p_13x11_after_rst", 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_4bits.md
Name: multi_4bits

Overview:
- Sequential unsigned multiplier that computes P = A * B with an iterative shift-add datapath.
- Runs continuously with no handshake. Whenever the operand inputs change, it recomputes automatically and updates the registered product.
- Used as a top-level arithmetic tile. Consumers hold operands stable for at least bits+3 clock cycles before sampling P.

Parameters:
bits, 4, operand width in bits; product width is 2*bits.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
A  input  bits  unsigned multiplicand
B  input  bits  unsigned multiplier
P  output  2*bits  registered unsigned product A*B

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset is asynchronous and active-high (rst).
  - While rst=1, all state clears immediately and holds: P=0, operand registers=0, accumulator=0, counter=0, state=IDLE.
- FSM states: IDLE, LOAD, CALC, DONE.
  - IDLE: each cycle, compare A/B with the latched operands opA/opB. On mismatch -> LOAD. Otherwise stay (P unchanged).
  - LOAD: opA<=A, opB<=B, acc<=0, mcand<=zero-extended A (2*bits wide), mplier<=B, cnt<=0 -> CALC.
  - CALC: one multiplier bit per cycle.
    - If mplier[0]=1: acc<=acc+mcand.
    - Then mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
    - After exactly bits CALC cycles -> DONE.
  - DONE: P<=acc -> IDLE.
- Operand change during LOAD/CALC/DONE (A!=opA or B!=opB):
  - Abort without writing P; next state is LOAD.
  - Exception: in DONE the write of P is still skipped. A stale product is never published.
- Latency: an input change sampled at edge k yields the new P after edge k+bits+2 (6 cycles for bits=4). Bound for consumers: bits+3 cycles.
- Output stability:
  - P changes only in DONE.
  - P holds its previous value throughout a computation; no intermediate values appear.
- Arithmetic:
  - Fully unsigned. The accumulator is 2*bits wide, so max (2^bits-1)^2 fits without overflow.
  - For bits=4: 15*15=225.
  - Zero operand gives P=0.
- Reset release with A=B=0: no recomputation needed; P=0 is already correct.
- Reset asserted mid-computation: immediate clear; computation restarts after release only if the inputs are nonzero.
- Inputs are assumed synchronous to clk; no synchronizers are provided.

Optional Feature:
MULTI_COMB_EN
- Defined:
  - The iterative FSM is compiled out.
  - P<=A*B (combinational product) is registered on every rising edge; latency is 1 cycle.
  - Reset behaviour is identical (P=0 asynchronously).
- Undefined: shift-add FSM as specified above.
- Both builds produce identical P after bits+3 stable cycles.

Test Plan:
- Assert rst for 1 cycle with A=0,B=0; release. -> P=0 during reset and after 10 cycles.
- A=3,B=5, hold 10 cycles -> P=15. Then A=15,B=15 for 10 cycles -> P=225.
- A=0,B=9 after prior P=225 -> P stays 225 until DONE, then becomes 0 within 7 cycles.
- A=7,B=6 for 2 cycles, then A=9,B=9 held -> P never equals 42; P=81 within 7 cycles of the change.
- Exhaustive sweep, A=0..15 outer, B=0..15 inner, each held 10 cycles (100 ns at 100 MHz) -> sampled P == A*B for all 256 pairs.
- A=13,B=11, assert rst asynchronously at cycle 3 of CALC -> P=0 immediately. After release with inputs held -> P=143 within 7 cycles.
